// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared state type, default widths and width helpers for the systolic array
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DRAIN
    } sa_state_t;

    localparam int SA_WIDTH   = 8;
    localparam int SA_C_WIDTH = 32;
    localparam int SA_PROD_W  = 2 * SA_WIDTH;
    localparam int SA_EXT_W   = SA_C_WIDTH - SA_PROD_W;

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

    function automatic int idx_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/sa_os_array_if.sv
// rtl/sa_os_array_if.sv - operand beat stream and result row stream of the systolic array
interface sa_os_array_if #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int WIDTH   = 8,
    parameter int C_WIDTH = 32
) ();
    import sa_pkg::*;

    localparam int IDX_W = idx_width(ROWS);

    logic                     in_valid;
    logic                     in_ready;
    logic [ROWS*WIDTH-1:0]    activation;
    logic [COLS*WIDTH-1:0]    weight;
    logic                     out_valid;
    logic                     out_ready;
    logic [COLS*C_WIDTH-1:0]  out_row;
    logic [IDX_W-1:0]         out_idx;

    modport slave (
        input  in_valid, activation, weight, out_ready,
        output in_ready, out_valid, out_row, out_idx
    );

    modport master (
        output in_valid, activation, weight, out_ready,
        input  in_ready, out_valid, out_row, out_idx
    );

endinterface

// File: rtl/sa_os_pe.sv
// rtl/sa_os_pe.sv - one processing element: operand pass-through registers and a wrapping MAC
module sa_os_pe
    import sa_pkg::*;
#(
    parameter int WIDTH   = SA_WIDTH,
    parameter int C_WIDTH = SA_C_WIDTH
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clear,
    input  logic                      mac_en,
    input  logic signed [WIDTH-1:0]   a_in,
    input  logic signed [WIDTH-1:0]   w_in,
    output logic signed [WIDTH-1:0]   a_out,
    output logic signed [WIDTH-1:0]   w_out,
    output logic signed [C_WIDTH-1:0] acc
);

    localparam int PROD_W = prod_width(WIDTH);

    logic signed [PROD_W-1:0]  prod;
    logic signed [C_WIDTH-1:0] prod_ext;

    assign prod     = PROD_W'(a_in) * PROD_W'(w_in);
    assign prod_ext = C_WIDTH'(prod);

    // Zero operands during bubbles and flush make every extra MAC cycle a no-op.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_out <= '0;
            w_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            w_out <= w_in;
            if (clear) begin
                acc <= '0;
            end else if (mac_en) begin
                acc <= acc + prod_ext;
            end
        end
    end

endmodule

// File: rtl/sa_os_array.sv
// rtl/sa_os_array.sv - parametrised output-stationary systolic array with input skew, FSM and row drain
module sa_os_array
    import sa_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int WIDTH   = SA_WIDTH,
    parameter int C_WIDTH = SA_C_WIDTH,
    parameter int K_W     = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start,
    input  logic           acc_keep,
    input  logic [K_W-1:0] k_len,
    output logic           busy,
    output logic           done,
    sa_os_array_if.slave   bus
);

    localparam int IDX_W     = idx_width(ROWS);
    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int FL_W      = $clog2(FLUSH_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

    sa_state_t        state;
    sa_state_t        state_nx;
    logic [K_W-1:0]   beat_cnt;
    logic [FL_W-1:0]  flush_cnt;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             row_take;
    logic             clear_acc;
    logic             mac_en;

    logic signed [WIDTH-1:0]   a_edge [ROWS];
    logic signed [WIDTH-1:0]   w_edge [COLS];
    logic signed [WIDTH-1:0]   a_h    [ROWS][COLS];
    logic signed [WIDTH-1:0]   w_v    [ROWS][COLS];
    logic signed [C_WIDTH-1:0] acc    [ROWS][COLS];

    assign accept    = bus.in_valid && (state == LOAD);
    assign row_take  = bus.out_ready && (state == DRAIN);
    assign clear_acc = (state == IDLE) && start && !acc_keep;
    assign mac_en    = (state == LOAD) || (state == FLUSH);
    assign busy      = (state != IDLE);
    assign bus.out_idx = idx;

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (k_len == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && beat_cnt == K_W'(1)) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt == FL_W'(1)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready && idx == LAST_ROW) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            idx       <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= row_take && (idx == LAST_ROW);
            if (state == IDLE && start) begin
                beat_cnt <= k_len;
            end else if (accept) begin
                beat_cnt <= beat_cnt - K_W'(1);
            end
            // Reloaded every LOAD cycle so FLUSH always starts from the full count.
            if (state == LOAD) begin
                flush_cnt <= FL_W'(FLUSH_LEN);
            end else if (state == FLUSH) begin
                flush_cnt <= flush_cnt - FL_W'(1);
            end
            if (state == IDLE) begin
                idx <= '0;
            end else if (row_take) begin
                idx <= (idx == LAST_ROW) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Row r and column c are delayed r and c cycles so operands of one beat meet on the diagonal.
    for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
        logic signed [WIDTH-1:0] lane;
        assign lane = accept ? bus.activation[(ROWS-r)*WIDTH-1 -: WIDTH] : '0;
        if (r == 0) begin : g_direct
            assign a_edge[r] = lane;
        end else begin : g_delay
            logic signed [WIDTH-1:0] sr [r];
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    for (int i = 0; i < r; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= lane;
                    for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
                end
            end
            assign a_edge[r] = sr[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col_skew
        logic signed [WIDTH-1:0] lane;
        assign lane = accept ? bus.weight[(COLS-c)*WIDTH-1 -: WIDTH] : '0;
        if (c == 0) begin : g_direct
            assign w_edge[c] = lane;
        end else begin : g_delay
            logic signed [WIDTH-1:0] sr [c];
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    for (int i = 0; i < c; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= lane;
                    for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
                end
            end
            assign w_edge[c] = sr[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_r
        for (genvar c = 0; c < COLS; c++) begin : g_c
            logic signed [WIDTH-1:0] a_src;
            logic signed [WIDTH-1:0] w_src;
            if (c == 0) begin : g_a_edge
                assign a_src = a_edge[r];
            end else begin : g_a_mesh
                assign a_src = a_h[r][c-1];
            end
            if (r == 0) begin : g_w_edge
                assign w_src = w_edge[c];
            end else begin : g_w_mesh
                assign w_src = w_v[r-1][c];
            end
            sa_os_pe #(
                .WIDTH   (WIDTH),
                .C_WIDTH (C_WIDTH)
            ) u_pe (
                .clk    (clk),
                .rstn   (rstn),
                .clear  (clear_acc),
                .mac_en (mac_en),
                .a_in   (a_src),
                .w_in   (w_src),
                .a_out  (a_h[r][c]),
                .w_out  (w_v[r][c]),
                .acc    (acc[r][c])
            );
        end
    end

    always_comb begin
        bus.out_row = '0;
        if (state == DRAIN) begin
            for (int c = 0; c < COLS; c++) begin
                bus.out_row[(COLS-c)*C_WIDTH-1 -: C_WIDTH] = acc[idx][c];
            end
        end
    end

    // The far-edge pass-through registers feed nothing.
    logic unused_edge;
    always_comb begin
        unused_edge = 1'b0;
        for (int r = 0; r < ROWS; r++) unused_edge = unused_edge ^ (^a_h[r][COLS-1]);
        for (int c = 0; c < COLS; c++) unused_edge = unused_edge ^ (^w_v[ROWS-1][c]);
    end

endmodule

// File: tb/tb_sa_os_array.sv
// tb/tb_sa_os_array.sv - self-checking bench for sa_os_array against a matrix-product model
module tb_sa_os_array;
    import sa_pkg::*;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int W  = 8;
    localparam int CW = 32;
    localparam int KW = 16;
    localparam int CW2 = 16;

    typedef struct {
        int          pat;
        bit          keep;
        int          klen;
        int          gap;
        bit          stall;
        bit          lat;
        bit          has_exp;
        logic [31:0] e00;
        logic [31:0] e11;
        logic [31:0] e33;
    } job_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rstn, start, acc_keep, busy, done;
    logic [KW-1:0] k_len;
    logic          start2, busy2, done2;
    logic [KW-1:0] k_len2;

    sa_os_array_if #(.ROWS(R), .COLS(C), .WIDTH(W), .C_WIDTH(CW)) bus ();
    sa_os_array_if #(.ROWS(2), .COLS(2), .WIDTH(W), .C_WIDTH(CW2)) bus2 ();

    sa_os_array #(.ROWS(R), .COLS(C), .WIDTH(W), .C_WIDTH(CW), .K_W(KW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .acc_keep(acc_keep), .k_len(k_len),
        .busy(busy), .done(done), .bus(bus)
    );

    sa_os_array #(.ROWS(2), .COLS(2), .WIDTH(W), .C_WIDTH(CW2), .K_W(KW)) dut2 (
        .clk(clk), .rstn(rstn), .start(start2), .acc_keep(1'b0), .k_len(k_len2),
        .busy(busy2), .done(done2), .bus(bus2)
    );

    int     checks = 0;
    int     errors = 0;
    int     ba [64][R];
    int     bw [64][C];
    longint mdl [R][C];
    logic [CW-1:0] got [R][C];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // A[r][k] and W[k][c] per beat k, by pattern number.
    task automatic fill_pat(input int pat, input int klen);
        for (int k = 0; k < klen; k++) begin
            for (int i = 0; i < 4; i++) begin
                case (pat)
                    1: begin
                        ba[k][i] = (i < 2 && k < 2) ? 2 * i + k + 1 : 0;
                        bw[k][i] = (i < 2 && k < 2) ? 5 + 2 * k + i : 0;
                    end
                    2: begin
                        ba[k][i] = (i == k) ? 1 : 0;
                        bw[k][i] = 4 * k + i + 1;
                    end
                    3: begin ba[k][i] = 1; bw[k][i] = 1; end
                    4: begin ba[k][i] = -128; bw[k][i] = -128; end
                    5: begin
                        ba[k][i] = int'($urandom_range(0, 255)) - 128;
                        bw[k][i] = int'($urandom_range(0, 255)) - 128;
                    end
                    default: begin ba[k][i] = 0; bw[k][i] = 0; end
                endcase
            end
        end
    endtask

    function automatic logic [R*W-1:0] pack_a(input int k);
        logic [R*W-1:0] v;
        v = '0;
        for (int r = 0; r < R; r++) v[(R-r)*W-1 -: W] = W'(ba[k][r]);
        return v;
    endfunction

    function automatic logic [C*W-1:0] pack_w(input int k);
        logic [C*W-1:0] v;
        v = '0;
        for (int c = 0; c < C; c++) v[(C-c)*W-1 -: W] = W'(bw[k][c]);
        return v;
    endfunction

    task automatic run_job(input job_t j);
        int k;
        int guard;
        int t_first;
        bit v;
        bit stable;
        logic [C*CW-1:0] exp_row;
        logic [C*CW-1:0] snap;
        logic [1:0]      sidx;
        fill_pat(j.pat, j.klen);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                if (!j.keep) mdl[r][c] = 0;
                for (int q = 0; q < j.klen; q++) mdl[r][c] += longint'(ba[q][r]) * longint'(bw[q][c]);
            end
        end
        start = 1'b1; acc_keep = j.keep; k_len = KW'(j.klen);
        @(negedge clk);
        start = 1'b0; acc_keep = 1'b0; k_len = '0;
        chk("busy_after_start", busy, 1'b1);
        k = 0; guard = 0; t_first = 0;
        while (k < j.klen && guard < 500) begin
            v = (j.gap == 0) || (j.gap == 1 && guard % 2 == 0) || (j.gap == 2 && $urandom_range(0, 2) != 0);
            bus.in_valid   = v;
            bus.activation = v ? pack_a(k) : R*W'($urandom);
            bus.weight     = v ? pack_w(k) : C*W'($urandom);
            start = (j.gap == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            k_len = KW'($urandom_range(0, 3));
            if (v && bus.in_ready) begin
                if (k == 0) t_first = cyc;
                k++;
            end
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0; start = 1'b0; k_len = '0;
        chk("beats_accepted", k, j.klen);
        guard = 0;
        while (!bus.out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (j.klen == 0) chk("k0_direct_drain", guard, 0);
        if (j.lat && j.klen > 0) chk("first_out_latency", cyc - t_first, j.klen + R + C - 1);
        for (int r = 0; r < R; r++) begin
            guard = 0;
            while (!bus.out_valid && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (j.stall && r == 1) begin
                snap = bus.out_row; sidx = bus.out_idx; stable = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    if (bus.out_row !== snap || bus.out_idx !== sidx || bus.out_valid !== 1'b1) stable = 1'b0;
                end
                chk("stall_hold", stable, 1'b1);
            end
            for (int c = 0; c < C; c++) exp_row[(C-c)*CW-1 -: CW] = CW'(mdl[r][c]);
            chk("row_idx", bus.out_idx, r);
            chk("row_data", bus.out_row, exp_row);
            for (int c = 0; c < C; c++) got[r][c] = bus.out_row[(C-c)*CW-1 -: CW];
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        chk("done_pulse_idle", {done, busy}, 2'b10);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        if (j.has_exp) begin
            chk("tbl_acc00", got[0][0], j.e00);
            chk("tbl_acc11", got[1][1], j.e11);
            chk("tbl_acc33", got[3][3], j.e33);
        end
    endtask

    task automatic small_job(input int pat, input int klen, input logic [31:0] e0, input logic [31:0] e1);
        int guard;
        fill_pat(pat, klen);
        start2 = 1'b1; k_len2 = KW'(klen);
        @(negedge clk);
        start2 = 1'b0; k_len2 = '0;
        for (int k = 0; k < klen; k++) begin
            bus2.in_valid   = 1'b1;
            bus2.activation = {W'(ba[k][0]), W'(ba[k][1])};
            bus2.weight     = {W'(bw[k][0]), W'(bw[k][1])};
            @(negedge clk);
        end
        bus2.in_valid = 1'b0;
        guard = 0;
        while (!bus2.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("small_row0", {bus2.out_idx, bus2.out_row}, {1'b0, e0});
        bus2.out_ready = 1'b1;
        @(negedge clk);
        chk("small_row1", {bus2.out_idx, bus2.out_row}, {1'b1, e1});
        @(negedge clk);
        bus2.out_ready = 1'b0;
        chk("small_done", {done2, busy2}, 2'b10);
        @(negedge clk);
        chk("small_done_end", done2, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        job_t tbl [11];
        int   seen;
        tbl[0]  = '{1, 1'b0, 2,  0, 1'b0, 1'b1, 1'b1, 32'd19,    32'd50,    32'd0};
        tbl[1]  = '{2, 1'b0, 4,  1, 1'b0, 1'b0, 1'b1, 32'd1,     32'd6,     32'd16};
        tbl[2]  = '{2, 1'b0, 4,  0, 1'b1, 1'b1, 1'b1, 32'd1,     32'd6,     32'd16};
        tbl[3]  = '{3, 1'b0, 4,  0, 1'b0, 1'b1, 1'b1, 32'd4,     32'd4,     32'd4};
        tbl[4]  = '{3, 1'b1, 4,  2, 1'b0, 1'b0, 1'b1, 32'd8,     32'd8,     32'd8};
        tbl[5]  = '{3, 1'b0, 4,  0, 1'b1, 1'b1, 1'b1, 32'd4,     32'd4,     32'd4};
        tbl[6]  = '{4, 1'b0, 1,  0, 1'b0, 1'b1, 1'b1, 32'd16384, 32'd16384, 32'd16384};
        tbl[7]  = '{0, 1'b0, 0,  0, 1'b0, 1'b0, 1'b1, 32'd0,     32'd0,     32'd0};
        tbl[8]  = '{5, 1'b0, 5,  2, 1'b0, 1'b0, 1'b0, 32'd0,     32'd0,     32'd0};
        tbl[9]  = '{5, 1'b1, 7,  2, 1'b1, 1'b0, 1'b0, 32'd0,     32'd0,     32'd0};
        tbl[10] = '{5, 1'b0, 16, 0, 1'b0, 1'b1, 1'b0, 32'd0,     32'd0,     32'd0};

        rstn = 1'b0; start = 1'b0; acc_keep = 1'b0; k_len = '0;
        start2 = 1'b0; k_len2 = '0;
        bus.in_valid = 1'b0; bus.activation = '0; bus.weight = '0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.activation = '0; bus2.weight = '0; bus2.out_ready = 1'b0;
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) mdl[r][c] = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk("reset_ctl", {busy, done, bus.in_ready, bus.out_valid, bus.out_idx}, '0);
        chk("reset_row", bus.out_row, '0);

        small_job(1, 2, {16'd19, 16'd22}, {16'd43, 16'd50});
        small_job(4, 1, 32'h4000_4000, 32'h4000_4000);
        small_job(4, 2, 32'h8000_8000, 32'h8000_8000);

        for (int i = 0; i < 11; i++) run_job(tbl[i]);

        fill_pat(3, 8);
        start = 1'b1; acc_keep = 1'b1; k_len = KW'(8);
        @(negedge clk);
        start = 1'b0; acc_keep = 1'b0; k_len = '0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1; bus.activation = pack_a(k); bus.weight = pack_w(k);
            @(negedge clk);
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1; bus.in_valid = 1'b0;
        chk("midload_reset_ctl", {busy, done, bus.in_ready, bus.out_valid, bus.out_idx}, '0);
        chk("midload_reset_row", bus.out_row, '0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || bus.out_valid || busy) seen++;
        end
        chk("midload_no_done", seen, 0);
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) mdl[r][c] = 0;
        run_job('{3, 1'b1, 4, 0, 1'b0, 1'b1, 1'b1, 32'd4, 32'd4, 32'd4});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
